// File: rtl/pcafit_pkg.sv
// pcafit_pkg: shared hit types, fitter register map and streamer FSM states
package pcafit_pkg;

    localparam int COORD_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } hit_t;

    typedef struct packed {
        logic last;
        hit_t hit;
    } entry_t;

    localparam logic [1:0] FIT_REG0 = 2'd0;
    localparam logic [1:0] FIT_REG1 = 2'd1;
    localparam logic [1:0] FIT_REG2 = 2'd2;
    localparam logic [1:0] FIT_REG3 = 2'd3;

    typedef enum logic [1:0] {IDLE, CFG, STREAM, GAP} state_e;

    // Maps the k-th configuration beat to its fitter register address
    function automatic logic [1:0] reg_addr(input logic [1:0] k);
        return k == 2'd0 ? FIT_REG0 : k == 2'd1 ? FIT_REG1 : k == 2'd2 ? FIT_REG2 : FIT_REG3;
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// hit_fifo: synchronous hit buffer reporting full, empty and occupancy
module hit_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [W-1:0]            wdata_i,
    input  logic                    pop_i,
    output logic [W-1:0]            rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap on their own because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/hit_streamer.sv
// hit_streamer: buffers hit tracks, streams them to the fitter and programs its registers
module hit_streamer
    import pcafit_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hit_valid,
    output logic               hit_ready,
    input  logic [COORD_W-1:0] hit_x,
    input  logic [COORD_W-1:0] hit_y,
    input  logic [COORD_W-1:0] hit_z,
    input  logic               hit_last,
    input  logic               cfg_start,
    input  logic [31:0]        cfg_data,
    output logic               cfg_busy,
    output logic               dv_in_0,
    output logic [COORD_W-1:0] data_in_x_0,
    output logic [COORD_W-1:0] data_in_y_0,
    output logic [COORD_W-1:0] data_in_z_0,
    output logic               mem_en,
    output logic               mem_rd_wr,
    output logic [1:0]         mem_add,
    output logic [7:0]         mem_data,
    output logic [15:0]        trk_sent_cnt,
    output logic               err_overlong
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + GAP_CYCLES + 4);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] cfg_q, cfg_d;
    logic [AW:0] pend_q, fifo_cnt;
    logic [15:0] trk_cnt_q;
    hit_t        data_q;
    entry_t      wr_entry, rd_entry;
    logic        err_q, dv_q, alive_q, trk_inc, overlong;
    logic        fifo_full, fifo_empty, push, pop;

    assign push     = hit_valid && hit_ready;
    assign pop      = state_q == STREAM && !fifo_empty;
    assign wr_entry = {hit_last, hit_x, hit_y, hit_z};

    hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Sequencer: CFG beats, STREAM pop count and GAP length all share cnt_q
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg_q;
        trk_inc  = 1'b0;
        overlong = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = CFG;
                    cnt_d   = '0;
                    cfg_d   = cfg_data;
                end else if (pend_q != '0 || fifo_cnt == (AW+1)'(FIFO_DEPTH)) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end
            CFG: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(3)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (pop) begin
                    cnt_d = cnt_q + CW'(1);
                    if (rd_entry.last || cnt_q == CW'(FIFO_DEPTH - 1)) begin
                        state_d  = GAP;
                        cnt_d    = '0;
                        trk_inc  = rd_entry.last;
                        overlong = !rd_entry.last;
                    end
                end
            end
            GAP: begin
                // The first GAP cycle still shows the final registered hit, so GAP spans
                // GAP_CYCLES+1 cycles to leave exactly GAP_CYCLES cycles of dv low
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(GAP_CYCLES)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, shared counter and latched register image
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
        end
    end

    // Complete tracks held in the buffer: up on an accepted last hit, down on a popped one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend_q <= '0;
        else        pend_q <= pend_q + (AW+1)'(push && hit_last) - (AW+1)'(pop && rd_entry.last);
    end

    // Registered fitter stream, track counter, sticky error and post-reset ready enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv_q      <= 1'b0;
            data_q    <= '0;
            trk_cnt_q <= '0;
            err_q     <= 1'b0;
            alive_q   <= 1'b0;
        end else begin
            dv_q      <= pop;
            data_q    <= pop ? rd_entry.hit : data_q;
            trk_cnt_q <= trk_cnt_q + 16'(trk_inc);
            err_q     <= err_q | overlong;
            alive_q   <= 1'b1;
        end
    end

    assign hit_ready    = alive_q && !fifo_full;
    assign dv_in_0      = dv_q;
    assign data_in_x_0  = data_q.x;
    assign data_in_y_0  = data_q.y;
    assign data_in_z_0  = data_q.z;
    assign cfg_busy     = state_q == CFG;
    assign mem_en       = cfg_busy;
    assign mem_rd_wr    = cfg_busy;
    assign mem_add      = cfg_busy ? reg_addr(cnt_q[1:0]) : 2'd0;
    assign mem_data     = cfg_busy ? 8'(cfg_q >> {cnt_q[1:0], 3'b000}) : 8'd0;
    assign trk_sent_cnt = trk_cnt_q;
    assign err_overlong = err_q;

endmodule

// File: tb/tb_hit_streamer.sv
// tb_hit_streamer: scoreboard bench for the hit streamer
module tb_hit_streamer;
    import pcafit_pkg::*;

    logic        clk = 1'b0, reset = 1'b0;
    logic        hit_valid = 1'b0, hit_last = 1'b0, cfg_start = 1'b0;
    logic [7:0]  hit_x = '0, hit_y = '0, hit_z = '0;
    logic [31:0] cfg_data = '0;
    logic        hit_ready, cfg_busy, dv_in_0, mem_en, mem_rd_wr, err_overlong;
    logic [7:0]  data_in_x_0, data_in_y_0, data_in_z_0, mem_data;
    logic [1:0]  mem_add;
    logic [15:0] trk_sent_cnt;

    int          total = 0, passed = 0, dv_total = 0;
    logic [23:0] sb[$];

    hit_streamer #(.FIFO_DEPTH(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_x(hit_x), .hit_y(hit_y), .hit_z(hit_z), .hit_last(hit_last),
        .cfg_start(cfg_start), .cfg_data(cfg_data), .cfg_busy(cfg_busy),
        .dv_in_0(dv_in_0), .data_in_x_0(data_in_x_0), .data_in_y_0(data_in_y_0),
        .data_in_z_0(data_in_z_0), .mem_en(mem_en), .mem_rd_wr(mem_rd_wr),
        .mem_add(mem_add), .mem_data(mem_data), .trk_sent_cnt(trk_sent_cnt),
        .err_overlong(err_overlong)
    );

    always #5 clk = ~clk;

    // Scoreboard: every emitted hit must match the oldest accepted hit
    always @(negedge clk) begin
        if (reset && dv_in_0) begin
            dv_total++;
            total++;
            if (sb.size() == 0) $display("FAIL sb_unexpected_dv: got %h%h%h, required no dv", data_in_x_0, data_in_y_0, data_in_z_0);
            else begin
                logic [23:0] exp;
                exp = sb.pop_front();
                if ({data_in_x_0, data_in_y_0, data_in_z_0} !== exp)
                    $display("FAIL sb_data: got %h, required %h", {data_in_x_0, data_in_y_0, data_in_z_0}, exp);
                else passed++;
            end
        end
    end

    task automatic push_hit(input logic [7:0] x, y, z, input logic last);
        hit_valid = 1'b1; hit_x = x; hit_y = y; hit_z = z; hit_last = last;
        for (int i = 0; i < 200 && !hit_ready; i++) @(negedge clk);
        if (!hit_ready) begin
            total++;
            $display("FAIL push_timeout: hit_ready=%b, required 1", hit_ready);
        end else sb.push_back({x, y, z});
        @(negedge clk);
        hit_valid = 1'b0; hit_last = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({hit_ready, cfg_busy, dv_in_0, data_in_x_0, data_in_y_0, data_in_z_0, mem_en, mem_rd_wr, mem_add, mem_data, trk_sent_cnt, err_overlong} !== '0)
            $display("FAIL reset_outputs: ready=%b busy=%b dv=%b trk=%h err=%b, required all 0", hit_ready, cfg_busy, dv_in_0, trk_sent_cnt, err_overlong);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (hit_ready !== 1'b1) $display("FAIL reset_ready_rise: got %b, required 1", hit_ready); else passed++;
    endtask

    task automatic test_track();
        int run = 0;
        bit busy_seen = 0;
        settle();
        push_hit(8'd1, 8'd2, 8'd3, 1'b0);
        push_hit(8'd4, 8'd5, 8'd6, 1'b0);
        push_hit(8'd7, 8'd8, 8'd9, 1'b1);
        for (int i = 0; i < 50 && !dv_in_0; i++) @(negedge clk);
        total++;
        if (dv_in_0 !== 1'b1) $display("FAIL track_dv_timeout: got %b, required 1", dv_in_0); else passed++;
        while (dv_in_0 && run < 20) begin
            run++;
            if (run == 1) cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
            busy_seen |= cfg_busy;
        end
        total++;
        if (run !== 3) $display("FAIL track_dv_run: got %0d, required 3", run); else passed++;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dv_in_0 !== 1'b0) $display("FAIL track_gap_%0d: dv=%b, required 0", k, dv_in_0); else passed++;
            busy_seen |= cfg_busy;
            @(negedge clk);
        end
        busy_seen |= cfg_busy;
        total++;
        if (trk_sent_cnt !== 16'd1) $display("FAIL track_count: got %0d, required 1", trk_sent_cnt); else passed++;
        total++;
        if (busy_seen !== 1'b0) $display("FAIL cfg_outside_idle: busy seen=%b, required 0", busy_seen); else passed++;
    endtask

    task automatic test_cfg();
        logic [31:0] img;
        settle();
        img = 32'hA1B2C3D4;
        cfg_data = img; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; cfg_data = '0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b = 8'(img >> (8 * k));
            total++;
            if ({mem_en, mem_rd_wr, mem_add, mem_data, cfg_busy} !== {1'b1, 1'b1, 2'(k), b, 1'b1})
                $display("FAIL cfg_beat_%0d: en=%b wr=%b add=%0d data=%h busy=%b, required 1 1 %0d %h 1", k, mem_en, mem_rd_wr, mem_add, mem_data, cfg_busy, k, b);
            else passed++;
            @(negedge clk);
        end
        total++;
        if ({mem_en, cfg_busy} !== 2'b00) $display("FAIL cfg_end: en=%b busy=%b, required 0 0", mem_en, cfg_busy); else passed++;
    endtask

    task automatic test_priority();
        int run = 0;
        bit dv_in_cfg = 0;
        settle();
        push_hit(8'd10, 8'd11, 8'd12, 1'b0);
        hit_valid = 1'b1; hit_x = 8'd13; hit_y = 8'd14; hit_z = 8'd15; hit_last = 1'b1;
        for (int i = 0; i < 50 && !hit_ready; i++) @(negedge clk);
        sb.push_back({8'd13, 8'd14, 8'd15});
        @(negedge clk);
        hit_valid = 1'b0; hit_last = 1'b0; cfg_start = 1'b1; cfg_data = 32'h01020304;
        @(negedge clk);
        cfg_start = 1'b0;
        total++;
        if (cfg_busy !== 1'b1) $display("FAIL prio_cfg_first: busy=%b, required 1", cfg_busy); else passed++;
        for (int k = 0; k < 4; k++) begin
            dv_in_cfg |= dv_in_0;
            @(negedge clk);
        end
        total++;
        if (dv_in_cfg !== 1'b0) $display("FAIL prio_dv_in_cfg: got %b, required 0", dv_in_cfg); else passed++;
        for (int i = 0; i < 50 && !dv_in_0; i++) @(negedge clk);
        while (dv_in_0 && run < 20) begin
            run++;
            @(negedge clk);
        end
        total++;
        if (run !== 2) $display("FAIL prio_track_run: got %0d, required 2", run); else passed++;
    endtask

    task automatic test_back_to_back();
        int r1 = 0, g = 0, r2 = 0, ph = 0;
        settle();
        push_hit(8'd50, 8'd51, 8'd52, 1'b0);
        push_hit(8'd53, 8'd54, 8'd55, 1'b1);
        push_hit(8'd56, 8'd57, 8'd58, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (ph == 0 && dv_in_0) ph = 1;
            if (ph == 1) begin if (dv_in_0) r1++; else ph = 2; end
            if (ph == 2) begin if (!dv_in_0) g++; else ph = 3; end
            if (ph == 3) begin if (dv_in_0) r2++; else ph = 4; end
            @(negedge clk);
        end
        total++;
        if (r1 !== 2 || r2 !== 1) $display("FAIL b2b_runs: got %0d,%0d, required 2,1", r1, r2); else passed++;
        total++;
        if (g < 2) $display("FAIL b2b_gap: got %0d idle cycles, required at least 2", g); else passed++;
    endtask

    task automatic test_overlong();
        logic [15:0] base_trk;
        int base_dv;
        settle();
        base_trk = trk_sent_cnt;
        base_dv = dv_total;
        for (int i = 0; i < 8; i++) push_hit(8'(20 + i), 8'(120 + i), 8'(200 + i), 1'b0);
        total++;
        if (hit_ready !== 1'b0) $display("FAIL ovl_full_ready: got %b, required 0", hit_ready); else passed++;
        push_hit(8'd28, 8'd128, 8'd208, 1'b0);
        push_hit(8'd29, 8'd129, 8'd209, 1'b0);
        repeat (30) @(negedge clk);
        total++;
        if (dv_total - base_dv !== 8) $display("FAIL ovl_emitted: got %0d, required 8", dv_total - base_dv); else passed++;
        total++;
        if (err_overlong !== 1'b1) $display("FAIL ovl_err: got %b, required 1", err_overlong); else passed++;
        total++;
        if (trk_sent_cnt !== base_trk) $display("FAIL ovl_count: got %0d, required %0d", trk_sent_cnt, base_trk); else passed++;
        push_hit(8'd30, 8'd130, 8'd210, 1'b1);
        repeat (20) @(negedge clk);
        total++;
        if (dv_total - base_dv !== 11) $display("FAIL ovl_rest: got %0d, required 11", dv_total - base_dv); else passed++;
        total++;
        if (trk_sent_cnt !== base_trk + 16'd1) $display("FAIL ovl_rest_count: got %0d, required %0d", trk_sent_cnt, base_trk + 16'd1); else passed++;
        total++;
        if (sb.size() !== 0) $display("FAIL ovl_sb_drain: got %0d left, required 0", sb.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        bit found = 0, any_dv = 0;
        settle();
        push_hit(8'd40, 8'd1, 8'd1, 1'b0);
        push_hit(8'd41, 8'd2, 8'd2, 1'b0);
        push_hit(8'd42, 8'd3, 8'd3, 1'b0);
        push_hit(8'd43, 8'd4, 8'd4, 1'b1);
        for (int i = 0; i < 50 && !found; i++) begin
            if (dv_in_0 && data_in_x_0 == 8'd41) found = 1;
            else @(negedge clk);
        end
        total++;
        if (found !== 1'b1) $display("FAIL rst_mid_timeout: 2nd hit seen=%b, required 1", found); else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({hit_ready, cfg_busy, dv_in_0, data_in_x_0, data_in_y_0, data_in_z_0, mem_en, mem_add, mem_data, trk_sent_cnt, err_overlong} !== '0)
            $display("FAIL rst_mid_outputs: ready=%b dv=%b x=%h trk=%h err=%b, required all 0", hit_ready, dv_in_0, data_in_x_0, trk_sent_cnt, err_overlong);
        else passed++;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        total++;
        if (hit_ready !== 1'b0) $display("FAIL rst_mid_ready_low: got %b, required 0", hit_ready); else passed++;
        @(negedge clk);
        total++;
        if (hit_ready !== 1'b1) $display("FAIL rst_mid_ready_high: got %b, required 1", hit_ready); else passed++;
        for (int i = 0; i < 20; i++) begin
            any_dv |= dv_in_0;
            @(negedge clk);
        end
        total++;
        if (any_dv !== 1'b0) $display("FAIL rst_mid_no_dv: got %b, required 0", any_dv); else passed++;
    endtask

    task automatic test_wrap();
        settle();
        force dut.trk_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.trk_cnt_q;
        total++;
        if (trk_sent_cnt !== 16'hFFFE) $display("FAIL wrap_preload: got %h, required fffe", trk_sent_cnt); else passed++;
        push_hit(8'd90, 8'd91, 8'd92, 1'b1);
        repeat (10) @(negedge clk);
        total++;
        if (trk_sent_cnt !== 16'hFFFF) $display("FAIL wrap_ffff: got %h, required ffff", trk_sent_cnt); else passed++;
        push_hit(8'd93, 8'd94, 8'd95, 1'b1);
        repeat (10) @(negedge clk);
        total++;
        if (trk_sent_cnt !== 16'h0000) $display("FAIL wrap_zero: got %h, required 0000", trk_sent_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_track();
        test_cfg();
        test_priority();
        test_back_to_back();
        test_overlong();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/hit_streamer.md
HIT_STREAMER -- requirements
Module: hit_streamer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: hit buffer entries, power of two, minimum 4.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles forced after every emitted track, minimum 1.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 hit_valid  in  1  upstream hit present.
REQ-006 hit_ready  out  1  hit accepted on an edge where hit_valid and hit_ready are both high.
REQ-007 hit_x, hit_y, hit_z  in  8 each  hit coordinates.
REQ-008 hit_last  in  1  marks the final hit of a track.
REQ-009 cfg_start  in  1  single-cycle request to program the fitter registers.
REQ-010 cfg_data  in  32  register image; byte k is written to address k.
REQ-011 cfg_busy  out  1  configuration sequence in progress.
REQ-012 dv_in_0  out  1  hit strobe to the fitter.
REQ-013 data_in_x_0, data_in_y_0, data_in_z_0  out  8 each  hit coordinates to the fitter.
REQ-014 mem_en, mem_rd_wr  out  1 each  fitter register port strobe and direction (1 = write).
REQ-015 mem_add  out  2; mem_data  out  8  fitter register address and write data.
REQ-016 trk_sent_cnt  out  16  count of completed emitted tracks; wraps from 0xFFFF to 0.
REQ-017 err_overlong  out  1  sticky flag: a track exceeded FIFO_DEPTH hits.

Function
REQ-018 FSM states: IDLE, CFG, STREAM, GAP. The FSM SHALL leave the reset state in IDLE.
REQ-019 hit_ready SHALL equal NOT full, derived from registered occupancy; there is no combinational path from hit_valid to hit_ready.
REQ-020 An accepted hit SHALL be stored as {last,x,y,z}, and it SHALL be visible in the FIFO on the following cycle.
REQ-021 tracks_pending SHALL increment when a hit with last=1 is accepted and decrement when a hit with last=1 is popped; both events in the same cycle SHALL leave it unchanged.
REQ-022 IDLE with cfg_start=1: next state CFG. cfg_start outside IDLE SHALL be ignored, and cfg_start SHALL take priority over a pending track.
REQ-023 CFG SHALL drive four consecutive registered cycles with mem_en=1, mem_rd_wr=1, mem_add=0..3 and mem_data=cfg_data byte 0..3, where cfg_data is latched at the cfg_start edge; the FSM SHALL then return to IDLE; cfg_busy SHALL be high exactly during these 4 cycles.
REQ-024 IDLE, no cfg_start, with tracks_pending>0 or FIFO full: next state STREAM.
REQ-025 STREAM SHALL pop one hit per cycle and present it registered, with dv_in_0=1, in the cycle after the pop.
REQ-026 STREAM SHALL end after the cycle that pops a last=1 hit, or after FIFO_DEPTH pops with no last seen; next state is GAP.
REQ-027 The FIFO-full exit of REQ-026 (overlong track) SHALL set err_overlong and SHALL NOT increment trk_sent_cnt; the remaining hits of that track then form the next emitted track.
REQ-028 GAP SHALL hold dv_in_0=0 for exactly GAP_CYCLES cycles, then the FSM SHALL move to IDLE; trk_sent_cnt SHALL increment on entry to GAP for normal tracks.
REQ-029 Outside emitted hits, dv_in_0 SHALL be 0 and data_in_x/y/z_0 SHALL hold their last values; mem_en SHALL be 0 outside CFG.
REQ-030 Push SHALL remain permitted in every state, including during STREAM pops of the same FIFO.

Reset
REQ-031 reset low SHALL asynchronously clear all of the following: FSM to IDLE, FIFO pointers, occupancy, tracks_pending, and every output to 0 (hit_ready rises the first cycle after release).
REQ-032 Reset asserted mid-track or mid-CFG SHALL discard the partial data; no partial sequence resumes after release.

Structure
REQ-033 Shared package pcafit_pkg SHALL hold: the hit_t struct {x,y,z}, the coordinate width 8, the fitter register address constants 0..3, and the FSM state enum.
REQ-034 The FIFO SHALL be the sub-module hit_fifo (sync FIFO with parameter depth, providing full, empty and count); the FSM, counters and output registers SHALL live in hit_streamer.

Verification
REQ-035 Push a 3-hit track (1,2,3),(4,5,6),(7,8,9 last) -> dv_in_0 high for 3 consecutive cycles with matching data, then 2 idle cycles, trk_sent_cnt=1.
REQ-036 cfg_start with cfg_data=0xA1B2C3D4 -> 4 cycles mem_en=1, mem_add 0,1,2,3, mem_data D4,C3,B2,A1, cfg_busy high 4 cycles.
REQ-037 Track pending and cfg_start in the same IDLE cycle -> CFG runs first, then the track streams; no dv during CFG.
REQ-038 Push 10 hits with no last (FIFO_DEPTH=8) -> hit_ready low when full, 8 hits emitted, err_overlong=1, trk_sent_cnt unchanged.
REQ-039 Reset asserted during the 2nd hit of a 4-hit stream -> outputs 0 immediately; after release the FIFO is empty and no dv occurs without new input.
REQ-040 Preload trk_sent_cnt path with 65536 tracks -> count wraps to 0.
